// File: rtl/fp_add_arbiter.sv
// rtl/fp_add_arbiter.sv - round-robin arbiter sharing one pipelined FP add/sub datapath among NREQ requesters
module fp_add_arbiter #(
    parameter int WIDTH   = 24,
    parameter int NREQ    = 4,
    parameter int LATENCY = 3,
    parameter int MAX_OUT = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic [NREQ-1:0]       req_valid_i,
    output logic [NREQ-1:0]       req_ready_o,
    input  logic [NREQ*WIDTH-1:0] req_a_i,
    input  logic [NREQ*WIDTH-1:0] req_b_i,
    input  logic [NREQ*4-1:0]     req_op_i,
    output logic                  fpu_valid_o,
    output logic [WIDTH-1:0]      fpu_a_o,
    output logic [WIDTH-1:0]      fpu_b_o,
    output logic [3:0]            fpu_op_o,
    input  logic [WIDTH-1:0]      fpu_result_i,
    output logic [NREQ-1:0]       resp_valid_o,
    output logic [WIDTH-1:0]      resp_result_o,
    output logic                  busy_o
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(MAX_OUT + 1);
    localparam logic [IDW:0]  NREQ_C    = (IDW+1)'(NREQ);
    localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUT);

    logic [IDW-1:0]   ptr_q;
    logic [CW-1:0]    cnt_q [NREQ];
    logic [CW-1:0]    cnt_d [NREQ];
    logic             any_d;
    logic [NREQ-1:0]  elig;
    logic [IDW:0]     cand;
    logic             grant_any;
    logic [IDW-1:0]   grant_id;
    logic [NREQ-1:0]  grant_vec;
    logic [IDW:0]     ptr_inc;
    logic [IDW-1:0]   ptr_nxt;
    logic [IDW-1:0]   fpu_id_q;
    logic [LATENCY-1:0] tag_v_q;
    logic [IDW-1:0]   tag_id_q [LATENCY];
    logic [NREQ-1:0]  dec_vec;

    // A requester may compete only while below its in-flight limit (registered count, no bypass)
    always_comb begin
        elig = '0;
        for (int k = 0; k < NREQ; k++) begin
            elig[k] = req_valid_i[k] && (cnt_q[k] < MAX_OUT_C);
        end
    end

    // Round-robin search from ptr upward; reset and flush suppress any grant
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        cand      = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, ptr_q} + (IDW+1)'(i);
            if (cand >= NREQ_C) begin
                cand = cand - NREQ_C;
            end
            if (!grant_any && elig[cand[IDW-1:0]]) begin
                grant_any = 1'b1;
                grant_id  = cand[IDW-1:0];
            end
        end
        if (!rst_ni || flush_i) begin
            grant_any = 1'b0;
        end
    end

    // One-hot grant doubles as the ready handshake
    always_comb begin
        grant_vec = '0;
        if (grant_any) begin
            grant_vec[grant_id] = 1'b1;
        end
    end

    assign req_ready_o = grant_vec;

    // Pointer advances past the winner, wrapping at NREQ
    always_comb begin
        ptr_inc = {1'b0, grant_id} + (IDW+1)'(1);
        ptr_nxt = (ptr_inc == NREQ_C) ? '0 : ptr_inc[IDW-1:0];
    end

    // Round-robin pointer register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (grant_any) begin
            ptr_q <= ptr_nxt;
        end
    end

    // Issue register: capture the winner's operands at the handshake edge
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            fpu_valid_o <= 1'b0;
            fpu_a_o     <= '0;
            fpu_b_o     <= '0;
            fpu_op_o    <= '0;
            fpu_id_q    <= '0;
        end else if (flush_i) begin
            fpu_valid_o <= 1'b0;
        end else begin
            fpu_valid_o <= grant_any;
            if (grant_any) begin
                fpu_a_o  <= req_a_i[int'(grant_id)*WIDTH +: WIDTH];
                fpu_b_o  <= req_b_i[int'(grant_id)*WIDTH +: WIDTH];
                fpu_op_o <= req_op_i[int'(grant_id)*4 +: 4];
                fpu_id_q <= grant_id;
            end
        end
    end

    // Tag pipeline: last stage lines up with fpu_result_i for the matching op
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tag_v_q <= '0;
            for (int s = 0; s < LATENCY; s++) begin
                tag_id_q[s] <= '0;
            end
        end else begin
            tag_v_q[0]  <= fpu_valid_o && !flush_i;
            tag_id_q[0] <= fpu_id_q;
            for (int s = 1; s < LATENCY; s++) begin
                tag_v_q[s]  <= tag_v_q[s-1] && !flush_i;
                tag_id_q[s] <= tag_id_q[s-1];
            end
        end
    end

    // Completing op's requester; drives both the response pulse and the count decrement
    always_comb begin
        dec_vec = '0;
        if (tag_v_q[LATENCY-1]) begin
            dec_vec[tag_id_q[LATENCY-1]] = 1'b1;
        end
    end

    // Response register: one-cycle pulse, data holds between pulses
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            resp_valid_o  <= '0;
            resp_result_o <= '0;
        end else if (flush_i) begin
            resp_valid_o <= '0;
        end else begin
            resp_valid_o <= dec_vec;
            if (tag_v_q[LATENCY-1]) begin
                resp_result_o <= fpu_result_i;
            end
        end
    end

    // Next outstanding counts; the decrement lands on the edge that sets the response pulse
    always_comb begin
        any_d = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cnt_d[k] = cnt_q[k];
            case ({grant_vec[k], dec_vec[k]})
                2'b10:   cnt_d[k] = cnt_q[k] + CW'(1);
                2'b01:   cnt_d[k] = cnt_q[k] - CW'(1);
                default: cnt_d[k] = cnt_q[k];
            endcase
            if (cnt_d[k] != '0) begin
                any_d = 1'b1;
            end
        end
    end

    // Outstanding counters and busy flag
    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            for (int k = 0; k < NREQ; k++) begin
                cnt_q[k] <= '0;
            end
            busy_o <= 1'b0;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
            busy_o <= any_d;
        end
    end

    for (genvar k = 0; k < NREQ; k++) begin : g_cnt_chk
        a_cnt_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
            cnt_q[k] <= MAX_OUT_C);
        a_cnt_uflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
            !(dec_vec[k] && (cnt_q[k] == '0)));
    end

endmodule

// File: tb/tb_fp_add_arbiter.sv
// tb/tb_fp_add_arbiter.sv - self-checking bench for fp_add_arbiter
module tb_fp_add_arbiter;

    localparam int WIDTH = 24;
    localparam int NREQ  = 4;
    localparam int LAT   = 3;

    logic                  clk_i = 1'b0;
    logic                  rst_ni;
    logic                  flush_i;
    logic [NREQ-1:0]       req_valid_i;
    logic [NREQ-1:0]       req_ready_o;
    logic [NREQ*WIDTH-1:0] req_a_i;
    logic [NREQ*WIDTH-1:0] req_b_i;
    logic [NREQ*4-1:0]     req_op_i;
    logic                  fpu_valid_o;
    logic [WIDTH-1:0]      fpu_a_o;
    logic [WIDTH-1:0]      fpu_b_o;
    logic [3:0]            fpu_op_o;
    logic [WIDTH-1:0]      fpu_result_i;
    logic [NREQ-1:0]       resp_valid_o;
    logic [WIDTH-1:0]      resp_result_o;
    logic                  busy_o;

    fp_add_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .LATENCY(LAT), .MAX_OUT(2)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .flush_i       (flush_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_a_i       (req_a_i),
        .req_b_i       (req_b_i),
        .req_op_i      (req_op_i),
        .fpu_valid_o   (fpu_valid_o),
        .fpu_a_o       (fpu_a_o),
        .fpu_b_o       (fpu_b_o),
        .fpu_op_o      (fpu_op_o),
        .fpu_result_i  (fpu_result_i),
        .resp_valid_o  (resp_valid_o),
        .resp_result_o (resp_result_o),
        .busy_o        (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Stand-in datapath: fixed LAT-cycle pipe computing a recognisable function
    logic [WIDTH-1:0] dp_pipe [LAT];
    always @(posedge clk_i) begin
        dp_pipe[0] <= (fpu_a_o + fpu_b_o) ^ {20'h0, fpu_op_o};
        for (int s = 1; s < LAT; s++) dp_pipe[s] <= dp_pipe[s-1];
    end
    assign fpu_result_i = dp_pipe[LAT-1];

    function automatic logic [WIDTH-1:0] dp_model(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic [3:0] op);
        return (a + b) ^ {20'h0, op};
    endfunction

    typedef struct packed {
        logic [3:0] valid;
        logic [3:0] ready;
        logic       fv;
        logic [3:0] resp;
    } vec_t;

    typedef struct {
        int               id;
        logic [WIDTH-1:0] data;
    } sb_t;

    int   n_checks = 0;
    int   n_err    = 0;
    int   resp_seen = 0;
    sb_t  sb_q[$];
    vec_t tbl [33];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] v, input logic [3:0] r,
                                input logic f, input logic [3:0] s);
        vec_t t;
        t.valid = v; t.ready = r; t.fv = f; t.resp = s;
        return t;
    endfunction

    task automatic set_ops(input int seed);
        for (int k = 0; k < NREQ; k++) begin
            req_a_i[k*WIDTH +: WIDTH] = WIDTH'(seed*37 + k*4099 + 5);
            req_b_i[k*WIDTH +: WIDTH] = WIDTH'(seed*11 + k*257 + 3);
            req_op_i[k*4 +: 4]        = 4'(seed + k);
        end
    endtask

    // Observe one cycle: match responses against the grant-ordered scoreboard, record new grants
    task automatic sample();
        sb_t e;
        #1;
        if (resp_valid_o != '0) begin
            resp_seen++;
            if (sb_q.size() == 0) begin
                check("resp_unexpected", 32'(resp_valid_o), 32'h0);
            end else begin
                e = sb_q.pop_front();
                check("resp_id", 32'(resp_valid_o), 32'(4'b0001 << e.id));
                check("resp_data", 32'(resp_result_o), 32'(e.data));
            end
        end
        check("ready_within_valid", 32'(req_ready_o & ~req_valid_i), 32'h0);
        for (int k = 0; k < NREQ; k++) begin
            if (req_ready_o[k]) begin
                e.id   = k;
                e.data = dp_model(req_a_i[k*WIDTH +: WIDTH], req_b_i[k*WIDTH +: WIDTH],
                                  req_op_i[k*4 +: 4]);
                sb_q.push_back(e);
            end
        end
        if (flush_i || !rst_ni) sb_q.delete();
    endtask

    task automatic advance();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    initial begin
        int lat;
        int base;

        // Cycle-by-cycle vectors: 4-way rotation from ptr=0, drain, then req 2 alone hitting MAX_OUT
        tbl[0]  = mk(4'hF, 4'h1, 1'b0, 4'h0);
        tbl[1]  = mk(4'hF, 4'h2, 1'b1, 4'h0);
        tbl[2]  = mk(4'hF, 4'h4, 1'b1, 4'h0);
        tbl[3]  = mk(4'hF, 4'h8, 1'b1, 4'h0);
        tbl[4]  = mk(4'hF, 4'h1, 1'b1, 4'h0);
        tbl[5]  = mk(4'hF, 4'h2, 1'b1, 4'h1);
        tbl[6]  = mk(4'hF, 4'h4, 1'b1, 4'h2);
        tbl[7]  = mk(4'hF, 4'h8, 1'b1, 4'h4);
        tbl[8]  = mk(4'hF, 4'h1, 1'b1, 4'h8);
        tbl[9]  = mk(4'hF, 4'h2, 1'b1, 4'h1);
        tbl[10] = mk(4'h0, 4'h0, 1'b1, 4'h2);
        tbl[11] = mk(4'h0, 4'h0, 1'b0, 4'h4);
        tbl[12] = mk(4'h0, 4'h0, 1'b0, 4'h8);
        tbl[13] = mk(4'h0, 4'h0, 1'b0, 4'h1);
        tbl[14] = mk(4'h0, 4'h0, 1'b0, 4'h2);
        tbl[15] = mk(4'h0, 4'h0, 1'b0, 4'h0);
        tbl[16] = mk(4'h4, 4'h4, 1'b0, 4'h0);
        tbl[17] = mk(4'h4, 4'h4, 1'b1, 4'h0);
        tbl[18] = mk(4'h4, 4'h0, 1'b1, 4'h0);
        tbl[19] = mk(4'h4, 4'h0, 1'b0, 4'h0);
        tbl[20] = mk(4'h4, 4'h0, 1'b0, 4'h0);
        tbl[21] = mk(4'h4, 4'h4, 1'b0, 4'h4);
        tbl[22] = mk(4'h4, 4'h4, 1'b1, 4'h4);
        tbl[23] = mk(4'h4, 4'h0, 1'b1, 4'h0);
        tbl[24] = mk(4'h4, 4'h0, 1'b0, 4'h0);
        tbl[25] = mk(4'h4, 4'h0, 1'b0, 4'h0);
        tbl[26] = mk(4'h4, 4'h4, 1'b0, 4'h4);
        tbl[27] = mk(4'h0, 4'h0, 1'b1, 4'h4);
        tbl[28] = mk(4'h0, 4'h0, 1'b0, 4'h0);
        tbl[29] = mk(4'h0, 4'h0, 1'b0, 4'h0);
        tbl[30] = mk(4'h0, 4'h0, 1'b0, 4'h0);
        tbl[31] = mk(4'h0, 4'h0, 1'b0, 4'h4);
        tbl[32] = mk(4'h0, 4'h0, 1'b0, 4'h0);

        rst_ni      = 1'b0;
        flush_i     = 1'b0;
        req_valid_i = 4'hF;
        set_ops(0);
        @(negedge clk_i);
        for (int i = 0; i < 3; i++) begin
            sample();
            check("reset_ready_low", 32'(req_ready_o), 32'h0);
            advance();
        end
        rst_ni      = 1'b1;
        req_valid_i = 4'h0;
        sample();
        check("reset_fpu_valid", 32'(fpu_valid_o), 32'h0);
        check("reset_fpu_a", 32'(fpu_a_o), 32'h0);
        check("reset_resp_valid", 32'(resp_valid_o), 32'h0);
        check("reset_resp_result", 32'(resp_result_o), 32'h0);
        check("reset_busy", 32'(busy_o), 32'h0);
        advance();

        for (int i = 0; i < 33; i++) begin
            req_valid_i = tbl[i].valid;
            set_ops(i + 1);
            sample();
            check($sformatf("tbl%0d_ready", i), 32'(req_ready_o), 32'(tbl[i].ready));
            check($sformatf("tbl%0d_fpu_valid", i), 32'(fpu_valid_o), 32'(tbl[i].fv));
            check($sformatf("tbl%0d_resp", i), 32'(resp_valid_o), 32'(tbl[i].resp));
            advance();
        end

        // Single op on requester 1: 1.0 + 1.0
        req_valid_i = 4'b0010;
        req_a_i[1*WIDTH +: WIDTH] = 24'h3F8000;
        req_b_i[1*WIDTH +: WIDTH] = 24'h3F8000;
        req_op_i[4 +: 4] = 4'h0;
        sample();
        check("single_ready", 32'(req_ready_o), 32'h2);
        advance();
        req_valid_i = 4'h0;
        set_ops(77);
        sample();
        check("single_fpu_valid", 32'(fpu_valid_o), 32'h1);
        check("single_fpu_a", 32'(fpu_a_o), 32'h3F8000);
        check("single_fpu_b", 32'(fpu_b_o), 32'h3F8000);
        check("single_busy", 32'(busy_o), 32'h1);
        advance();
        lat = -1;
        for (int n = 0; n < 10; n++) begin
            sample();
            if (resp_valid_o != '0) begin
                lat = n;
                check("single_resp_id", 32'(resp_valid_o), 32'h2);
                check("single_resp_data", 32'(resp_result_o), 32'h7F0000);
                check("single_busy_fall", 32'(busy_o), 32'h0);
            end else begin
                check("single_busy_held", 32'(busy_o), 32'h1);
            end
            advance();
            if (lat >= 0) break;
        end
        check("single_latency", 32'(lat), 32'd3);
        sample();
        check("single_pulse_width", 32'(resp_valid_o), 32'h0);
        advance();

        // Flush with three ops in flight
        req_valid_i = 4'b1011;
        for (int i = 0; i < 3; i++) begin
            set_ops(200 + i);
            tick();
        end
        base        = resp_seen;
        req_valid_i = 4'b0100;
        flush_i     = 1'b1;
        sample();
        check("flush_no_grant", 32'(req_ready_o), 32'h0);
        check("flush_busy_before", 32'(busy_o), 32'h1);
        advance();
        flush_i = 1'b0;
        set_ops(210);
        sample();
        check("flush_busy_after", 32'(busy_o), 32'h0);
        check("flush_fpu_valid", 32'(fpu_valid_o), 32'h0);
        check("flush_regrant", 32'(req_ready_o), 32'h4);
        advance();
        req_valid_i = 4'h0;
        for (int i = 0; i < 12; i++) tick();
        check("flush_resp_count", 32'(resp_seen - base), 32'd1);

        // Random traffic: scoreboard catches lost, extra or misrouted responses
        for (int i = 0; i < 100; i++) begin
            req_valid_i = 4'($urandom_range(0, 15));
            set_ops(300 + i);
            tick();
        end
        req_valid_i = 4'h0;
        for (int i = 0; i < 10; i++) tick();
        check("rand_sb_empty", 32'(sb_q.size()), 32'h0);
        check("rand_busy_idle", 32'(busy_o), 32'h0);

        // Reset with two ops in flight
        req_valid_i = 4'b0011;
        for (int i = 0; i < 2; i++) begin
            set_ops(500 + i);
            tick();
        end
        rst_ni      = 1'b0;
        req_valid_i = 4'hF;
        sample();
        check("midrst_ready_low", 32'(req_ready_o), 32'h0);
        advance();
        rst_ni      = 1'b1;
        req_valid_i = 4'h0;
        sample();
        check("midrst_fpu_valid", 32'(fpu_valid_o), 32'h0);
        check("midrst_fpu_b", 32'(fpu_b_o), 32'h0);
        check("midrst_resp_valid", 32'(resp_valid_o), 32'h0);
        check("midrst_resp_result", 32'(resp_result_o), 32'h0);
        check("midrst_busy", 32'(busy_o), 32'h0);
        advance();
        base = resp_seen;
        for (int i = 0; i < 10; i++) tick();
        check("midrst_no_resp", 32'(resp_seen - base), 32'h0);
        req_valid_i = 4'b1100;
        set_ops(600);
        sample();
        check("midrst_ptr_zero", 32'(req_ready_o), 32'h4);
        advance();
        req_valid_i = 4'h0;
        for (int i = 0; i < 8; i++) tick();
        check("final_sb_empty", 32'(sb_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
